// File: rtl/ltcdrw_seq_if.sv
// ltcdrw_seq_if: bus bundle around the frame-scan sequencer.
//   Lattice RAM read port : mem_rd_en, mem_addr, mem_rd_data
//   ltcdrw converter link : ltc_in (to converter), ltc_out (from converter, {pix1, pix0})
//   ARGB pixel stream     : pix_valid, pix_ready, pix_data, pix_last
// Modports:
//   master - the sequencer side (drives reads, converter input and the pixel stream)
//   slave  - the environment side (RAM, converter, pixel sink)
interface ltcdrw_seq_if #(
  parameter int unsigned ADDR_W = 12
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [63:0]       mem_rd_data;
  logic [63:0]       ltc_in;
  logic [63:0]       ltc_out;
  logic              pix_valid;
  logic              pix_ready;
  logic [31:0]       pix_data;
  logic              pix_last;

  modport master (
    output mem_rd_en, mem_addr, ltc_in, pix_valid, pix_data, pix_last,
    input  mem_rd_data, ltc_out, pix_ready
  );

  modport slave (
    input  mem_rd_en, mem_addr, ltc_in, pix_valid, pix_data, pix_last,
    output mem_rd_data, ltc_out, pix_ready
  );
endinterface

// File: rtl/ltcdrw_seq.sv
// ltcdrw_seq: frame-scan sequencer for the lattice-to-ARGB draw path.
// On start it reads WORDS lattice words (addresses 0..WORDS-1), routes each returned word
// through the external ltcdrw converter, buffers the converted {pix1, pix0} words in a small
// FIFO and emits them as 32-bit ARGB pixels (low half first) on a valid/ready stream.
// Ports:
//   clk, rst     - clock (rising edge), asynchronous active-high reset
//   start        - 1-cycle pulse, begins a frame scan (ignored unless idle)
//   abort        - only with LTCDRW_SEQ_ABORT_EN: drop the current frame, no done pulse
//   busy         - high from start accept until the frame completes (or flush ends)
//   done         - 1-cycle pulse the cycle after the last pixel is accepted
//   bus (master) - lattice RAM read port, ltcdrw link and pixel stream (see ltcdrw_seq_if)
// Configuration macro: LTCDRW_SEQ_ABORT_EN adds the abort port and the FLUSH state.
module ltcdrw_seq #(
  parameter int unsigned WORDS  = 4096,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned DEPTH  = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
`ifdef LTCDRW_SEQ_ABORT_EN
  input  logic         abort,
`endif
  output logic         busy,
  output logic         done,
  ltcdrw_seq_if.master bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(WORDS - 1);

`ifdef LTCDRW_SEQ_ABORT_EN
  typedef enum logic [1:0] {StIdle, StRun, StDrain, StFlush} state_e;
`else
  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;
`endif

  state_e            state_q;
  logic              rd_en_q;
  logic [ADDR_W-1:0] addr_q;
  logic [RD_LAT-1:0] vld_q;      // one bit per read still travelling through the RAM
  logic [CntW-1:0]   occ_q;      // words issued and not yet popped (in flight + buffered)
  logic [CntW-1:0]   count_q;
  logic [PtrW-1:0]   wr_ptr_q;
  logic [PtrW-1:0]   rd_ptr_q;
  logic [63:0]       fifo_q [DEPTH];
  logic              half_q;
  logic [ADDR_W-1:0] pop_cnt_q;  // index of the word at the FIFO head
  logic              done_q;

  logic              pix_valid;
  logic              xfer;
  logic              push;
  logic              pop;
  logic              is_last;
  logic              issue;
  logic              can_issue;
  logic              abort_req;
  logic              flushing;
  logic [ADDR_W-1:0] issue_addr;
  logic [CntW-1:0]   occ_after;
  logic [63:0]       head;

`ifdef LTCDRW_SEQ_ABORT_EN
  assign abort_req = abort & ((state_q == StRun) | (state_q == StDrain));
  assign flushing  = (state_q == StFlush);
`else
  assign abort_req = 1'b0;
  assign flushing  = 1'b0;
`endif

  assign head      = fifo_q[rd_ptr_q];
  assign pix_valid = (count_q != '0);
  assign xfer      = pix_valid & bus.pix_ready;
  assign pop       = xfer & half_q;
  assign push      = vld_q[RD_LAT-1] & ~flushing & ~abort_req;
  assign is_last   = pix_valid & half_q & (pop_cnt_q == LastAddr);

  // Credit check counts this cycle's pop, so a word leaving the head frees a slot
  // immediately and 1 pixel/clk is sustained; a returned word always finds room.
  assign occ_after  = occ_q - CntW'(pop);
  assign can_issue  = (occ_after < CntW'(DEPTH));
  assign issue_addr = (state_q == StIdle) ? '0 : addr_q + ADDR_W'(1);

  always_comb begin
    issue = 1'b0;
    unique case (state_q)
      StIdle:  issue = start;
      StRun:   issue = can_issue & ~abort_req;
      default: issue = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      rd_en_q   <= 1'b0;
      addr_q    <= '0;
      vld_q     <= '0;
      occ_q     <= '0;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      half_q    <= 1'b0;
      pop_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      rd_en_q <= issue;
      vld_q   <= (vld_q << 1) | RD_LAT'(rd_en_q);
      if (issue) begin
        addr_q <= issue_addr;
      end
      if (abort_req) begin
`ifdef LTCDRW_SEQ_ABORT_EN
        state_q <= StFlush;
`endif
        occ_q     <= '0;
        count_q   <= '0;
        wr_ptr_q  <= '0;
        rd_ptr_q  <= '0;
        half_q    <= 1'b0;
        pop_cnt_q <= '0;
      end else begin
        occ_q   <= occ_after + CntW'(issue);
        count_q <= count_q + CntW'(push) - CntW'(pop);
        if (push) begin
          wr_ptr_q <= wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
          rd_ptr_q  <= rd_ptr_q + PtrW'(1);
          pop_cnt_q <= pop_cnt_q + ADDR_W'(1);
        end
        if (xfer) begin
          half_q <= ~half_q;
        end
        unique case (state_q)
          StIdle: begin
            if (start) begin
              state_q   <= (issue_addr == LastAddr) ? StDrain : StRun;
              half_q    <= 1'b0;
              pop_cnt_q <= '0;
            end
          end
          StRun: begin
            if (issue && (issue_addr == LastAddr)) begin
              state_q <= StDrain;
            end
          end
          StDrain: begin
            if (pop && is_last) begin
              state_q <= StIdle;
              done_q  <= 1'b1;
            end
          end
`ifdef LTCDRW_SEQ_ABORT_EN
          StFlush: begin
            // Stale returns are already discarded via push; wait until none remain.
            if (vld_q == '0) begin
              state_q <= StIdle;
            end
          end
`endif
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  // Storage needs no reset: occupancy is tracked by count_q and the output is gated.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= bus.ltc_out;
    end
  end

  assign bus.mem_rd_en = rd_en_q;
  assign bus.mem_addr  = addr_q;
  assign bus.ltc_in    = bus.mem_rd_data;
  assign bus.pix_valid = pix_valid;
  assign bus.pix_data  = pix_valid ? (half_q ? head[63:32] : head[31:0]) : '0;
  assign bus.pix_last  = is_last;
  assign busy          = (state_q != StIdle);
  assign done          = done_q;

endmodule

// File: tb/tb_ltcdrw_seq.sv
// tb_ltcdrw_seq: self-checking bench for ltcdrw_seq (WORDS=4, RD_LAT=2, DEPTH=4).
// A lattice RAM model with fixed read latency and a stand-in ltcdrw converter sit in the
// loop. Expected pixels come from a queue built straight from the RAM contents.
module tb_ltcdrw_seq;
  localparam int unsigned WORDS  = 4;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned RD_LAT = 2;
  localparam int unsigned DEPTH  = 4;

  typedef struct {
    int mode;          // 0 ready=1, 1 toggle 1/0, 2 random, 3 held low for 'stall' cycles
    int stall;
    bit restart;       // pulse start again while busy
    bit rand_mem;
    int exp_pix;
    int exp_reads;
    int exp_lat;       // start cycle -> first pix_valid
    int exp_last_cyc;  // cycle of last pixel transfer, -1 = not fixed
  } vec_t;

  logic clk;
  logic rst;
  logic start;
  logic busy;
  logic done;
  logic pix_ready;
`ifdef LTCDRW_SEQ_ABORT_EN
  logic abort;
`endif

  int checks;
  int errors;
  vec_t vecs[6];
  logic [63:0] lat_mem [WORDS];

  ltcdrw_seq_if #(.ADDR_W(ADDR_W)) bus ();

  ltcdrw_seq #(
    .WORDS (WORDS),
    .ADDR_W(ADDR_W),
    .RD_LAT(RD_LAT),
    .DEPTH (DEPTH)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
`ifdef LTCDRW_SEQ_ABORT_EN
    .abort(abort),
`endif
    .busy (busy),
    .done (done),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for ltcdrw: any fixed bijection works; the two halves use different masks.
  function automatic logic [63:0] ltc_f(input logic [63:0] x);
    return {x[55:0], x[63:56]} ^ 64'hFF00_FF00_0F0F_0F0F;
  endfunction

  // Lattice RAM: data appears RD_LAT cycles after the read strobe.
  logic [RD_LAT-1:0] rp_v;
  logic [ADDR_W-1:0] rp_a [RD_LAT];
  always @(posedge clk) begin
    if (rst) begin
      rp_v <= '0;
    end else begin
      rp_v <= {rp_v[RD_LAT-2:0], bus.mem_rd_en};
    end
    rp_a[0] <= bus.mem_addr;
    for (int i = 1; i < RD_LAT; i++) rp_a[i] <= rp_a[i-1];
  end
  assign bus.mem_rd_data = rp_v[RD_LAT-1] ? lat_mem[rp_a[RD_LAT-1]] : 64'hBAD0_BAD0_BAD0_BAD0;
  assign bus.ltc_out     = ltc_f(bus.ltc_in);
  assign bus.pix_ready   = pix_ready;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic ready_at(input int mode, input int cyc, input int stall);
    case (mode)
      0:       return 1'b1;
      1:       return (cyc % 2) == 0;
      2:       return 1'($urandom_range(0, 1));
      default: return cyc >= stall;
    endcase
  endfunction

  task automatic run_frame(input vec_t v);
    logic [31:0] exp_q[$];
    logic [63:0] w;
    logic [31:0] e;
    logic [31:0] prev_d;
    bit prev_v, prev_r, fin;
    int n_pix, n_reads, n_done, lat, last_cyc, done_cyc, reads_stall, tail;
    for (int n = 0; n < WORDS; n++) begin
      lat_mem[n] = v.rand_mem ? {$urandom(), $urandom()} : {8{8'(n + 1)}};
      w = ltc_f(lat_mem[n]);
      exp_q.push_back(w[31:0]);
      exp_q.push_back(w[63:32]);
    end
    n_pix = 0; n_reads = 0; n_done = 0; lat = -1; last_cyc = -1; done_cyc = -1;
    reads_stall = -1; tail = 0; fin = 0; prev_v = 0; prev_r = 0; prev_d = '0;
    @(posedge clk); #1;
    start     = 1'b1;
    pix_ready = ready_at(v.mode, 0, v.stall);
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      @(negedge clk);
      if (cyc == 0) check("busy_before_accept", busy, 0);
      if (cyc == 1) check("busy_after_start", busy, 1);
      if (bus.mem_rd_en) begin
        check("rd_addr", bus.mem_addr, n_reads);
        n_reads++;
      end
      if (cyc == v.stall - 1) reads_stall = n_reads;
      if (prev_v && !prev_r) begin
        check("hold_valid", bus.pix_valid, 1);
        check("hold_data", bus.pix_data, prev_d);
      end
      if (bus.pix_valid && lat < 0) lat = cyc;
      if (bus.pix_valid && pix_ready) begin
        n_pix++;
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("pix_data", bus.pix_data, e);
          check("pix_last", bus.pix_last, exp_q.size() == 0);
          if (exp_q.size() == 0) last_cyc = cyc;
        end
      end
      if (done) begin
        n_done++;
        check("busy_at_done", busy, 0);
        if (done_cyc < 0) done_cyc = cyc;
      end
      prev_v = bus.pix_valid;
      prev_r = pix_ready;
      prev_d = bus.pix_data;
      if (done_cyc >= 0) begin
        tail++;
        if (tail > 5) fin = 1;
      end
      @(posedge clk); #1;
      start     = (v.restart && (cyc + 1 == 3 || cyc + 1 == 7)) ? 1'b1 : 1'b0;
      pix_ready = ready_at(v.mode, cyc + 1, v.stall);
    end
    start = 1'b0;
    check("frame_completed", fin, 1);
    check("pixel_count", n_pix, v.exp_pix);
    check("read_count", n_reads, v.exp_reads);
    check("done_count", n_done, 1);
    check("first_valid_latency", lat, v.exp_lat);
    check("done_after_last", done_cyc, last_cyc + 1);
    check("busy_after_frame", busy, 0);
    if (v.stall > 0) check("reads_during_stall", reads_stall, v.exp_reads);
    if (v.exp_last_cyc >= 0) check("last_pixel_cycle", last_cyc, v.exp_last_cyc);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_rd_en"}, bus.mem_rd_en, 0);
    check({tag, "_addr"}, bus.mem_addr, 0);
    check({tag, "_valid"}, bus.pix_valid, 0);
    check({tag, "_data"}, bus.pix_data, 0);
    check({tag, "_last"}, bus.pix_last, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

`ifdef LTCDRW_SEQ_ABORT_EN
  int npix_ab, k_ab, nd_ab, nrd_ab;
`endif

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    start = 1'b0;
    pix_ready = 1'b0;
`ifdef LTCDRW_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    vecs[0] = '{mode: 0, stall: 0,  restart: 1'b0, rand_mem: 1'b0,
                exp_pix: 8, exp_reads: 4, exp_lat: 4, exp_last_cyc: 11};
    vecs[1] = '{mode: 3, stall: 20, restart: 1'b0, rand_mem: 1'b0,
                exp_pix: 8, exp_reads: 4, exp_lat: 4, exp_last_cyc: -1};
    vecs[2] = '{mode: 1, stall: 0,  restart: 1'b0, rand_mem: 1'b0,
                exp_pix: 8, exp_reads: 4, exp_lat: 4, exp_last_cyc: -1};
    vecs[3] = '{mode: 0, stall: 0,  restart: 1'b1, rand_mem: 1'b0,
                exp_pix: 8, exp_reads: 4, exp_lat: 4, exp_last_cyc: 11};
    vecs[4] = '{mode: 2, stall: 0,  restart: 1'b0, rand_mem: 1'b1,
                exp_pix: 8, exp_reads: 4, exp_lat: 4, exp_last_cyc: -1};
    vecs[5] = '{mode: 2, stall: 0,  restart: 1'b1, rand_mem: 1'b1,
                exp_pix: 8, exp_reads: 4, exp_lat: 4, exp_last_cyc: -1};

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    run_frame(vecs[0]);

    // Asynchronous reset in the middle of a frame, away from any clock edge.
    @(posedge clk); #1;
    start = 1'b1;
    pix_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    check("pre_reset_valid", bus.pix_valid, 1);
    check("pre_reset_busy", busy, 1);
    rst = 1'b1;
    #1;
    check_reset_outputs("midframe_reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 1; i < 6; i++) run_frame(vecs[i]);

`ifdef LTCDRW_SEQ_ABORT_EN
    // Abort after the second pixel, then a clean frame from address 0.
    @(posedge clk); #1;
    start = 1'b1;
    pix_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    npix_ab = 0;
    k_ab = 0;
    while (npix_ab < 2 && k_ab < 50) begin
      @(negedge clk);
      if (bus.pix_valid && pix_ready) npix_ab++;
      k_ab++;
      @(posedge clk); #1;
    end
    check("abort_two_pixels", npix_ab, 2);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_valid_drop", bus.pix_valid, 0);
    check("abort_busy_held", busy, 1);
    k_ab = 0;
    nd_ab = 0;
    nrd_ab = 0;
    while (busy && k_ab < 10) begin
      @(negedge clk);
      if (done) nd_ab++;
      if (bus.mem_rd_en) nrd_ab++;
      check("flush_valid", bus.pix_valid, 0);
      k_ab++;
      @(posedge clk); #1;
    end
    check("abort_busy_fell", busy, 0);
    check("abort_no_done", nd_ab, 0);
    check("abort_no_reads", nrd_ab, 0);
    run_frame(vecs[0]);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
